// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter/sequencer for port 0 of the 512x8 dual-port SRAM macro, 3-cycle read latency.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise requester A has fixed priority.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0
);

  logic grantA, grantB;
  logic aFire, bFire;

`ifdef SRAM_ARB_RR_EN
  // lastGrant_q: 1 = B was the most recent handshake, so A wins the next tie.
  logic lastGrant_q, lastGrant_d;

  always_comb begin
    grantA = a_valid && (!b_valid || lastGrant_q);
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (aFire)      lastGrant_d = 1'b0;
    else if (bFire) lastGrant_d = 1'b1;
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) lastGrant_q <= 1'b1;
    else        lastGrant_q <= lastGrant_d;
  end
`else
  always_comb begin
    grantA = a_valid;
  end
`endif

  always_comb begin
    grantB  = b_valid && !grantA;
    a_ready = rstb0 && grantA;
    b_ready = rstb0 && grantB;
    aFire   = a_valid && a_ready;
    bFire   = b_valid && b_ready;
  end

  logic                  memCsb_q, memCsb_d;
  logic                  memWeb_q, memWeb_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memDin_q, memDin_d;

  // Address and write data hold when idle so the macro inputs toggle only on real accesses.
  always_comb begin
    memCsb_d  = 1'b1;
    memWeb_d  = 1'b1;
    memAddr_d = memAddr_q;
    memDin_d  = memDin_q;
    if (aFire) begin
      memCsb_d  = 1'b0;
      memWeb_d  = ~a_we;
      memAddr_d = a_addr;
      memDin_d  = a_wdata;
    end else if (bFire) begin
      memCsb_d  = 1'b0;
      memWeb_d  = ~b_we;
      memAddr_d = b_addr;
      memDin_d  = b_wdata;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      memCsb_q  <= 1'b1;
      memWeb_q  <= 1'b1;
      memAddr_q <= '0;
      memDin_q  <= '0;
    end else begin
      memCsb_q  <= memCsb_d;
      memWeb_q  <= memWeb_d;
      memAddr_q <= memAddr_d;
      memDin_q  <= memDin_d;
    end
  end

  // Stage 1 lines up with the macro sampling its inputs, stage 2 with dout0 being valid.
  logic tag1Valid_q, tag1Valid_d, tag1IsB_q, tag1IsB_d;
  logic tag2Valid_q, tag2IsB_q;

  always_comb begin
    tag1Valid_d = (aFire && !a_we) || (bFire && !b_we);
    tag1IsB_d   = bFire;
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      tag1Valid_q <= 1'b0;
      tag1IsB_q   <= 1'b0;
      tag2Valid_q <= 1'b0;
      tag2IsB_q   <= 1'b0;
    end else begin
      tag1Valid_q <= tag1Valid_d;
      tag1IsB_q   <= tag1IsB_d;
      tag2Valid_q <= tag1Valid_q;
      tag2IsB_q   <= tag1IsB_q;
    end
  end

  logic                  aRvalid_q, aRvalid_d, bRvalid_q, bRvalid_d;
  logic [DATA_WIDTH-1:0] aRdata_q, aRdata_d, bRdata_q, bRdata_d;

  always_comb begin
    aRvalid_d = tag2Valid_q && !tag2IsB_q;
    bRvalid_d = tag2Valid_q && tag2IsB_q;
    aRdata_d  = aRvalid_d ? mem_dout0 : aRdata_q;
    bRdata_d  = bRvalid_d ? mem_dout0 : bRdata_q;
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      aRvalid_q <= 1'b0;
      bRvalid_q <= 1'b0;
      aRdata_q  <= '0;
      bRdata_q  <= '0;
    end else begin
      aRvalid_q <= aRvalid_d;
      bRvalid_q <= bRvalid_d;
      aRdata_q  <= aRdata_d;
      bRdata_q  <= bRdata_d;
    end
  end

  assign mem_csb0  = memCsb_q;
  assign mem_web0  = memWeb_q;
  assign mem_addr0 = memAddr_q;
  assign mem_din0  = memDin_q;
  assign a_rvalid  = aRvalid_q;
  assign a_rdata   = aRdata_q;
  assign b_rvalid  = bRvalid_q;
  assign b_rdata   = bRdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural model of the SRAM macro port 0.
// Contention expectations follow SRAM_ARB_RR_EN (round robin when defined, fixed A priority otherwise).
module tb_sram_port_arbiter;

   localparam int DW = 8;
   localparam int AW = 9;

   logic          clk0 = 1'b0;
   logic          rstb0;
   logic          a_valid, a_ready, a_we, a_rvalid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_rdata;
   logic          b_valid, b_ready, b_we, b_rvalid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic          mem_csb0, mem_web0;
   logic [AW-1:0] mem_addr0;
   logic [DW-1:0] mem_din0;
   logic [DW-1:0] mem_dout0;

   int checkCount = 0;
   int passCount  = 0;

   // 10-unit clock; inputs change 1 unit after posedge and checks follow 1 unit later.
   always #5 clk0 = ~clk0;

   sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk0(clk0), .rstb0(rstb0),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0), .mem_din0(mem_din0),
      .mem_dout0(mem_dout0)
   );

   // Macro model: port registered at posedge, write committed / read driven at the following negedge.
   logic [DW-1:0] memArray [512];
   logic          csbLat = 1'b1, webLat = 1'b1;
   logic [AW-1:0] addrLat = '0;
   logic [DW-1:0] dinLat = '0;

   initial begin
      mem_dout0 = '0;
      for (int i = 0; i < 512; i++) memArray[i] = 8'(i) ^ 8'hA5;
   end

   always @(posedge clk0) begin
      csbLat  <= mem_csb0;
      webLat  <= mem_web0;
      addrLat <= mem_addr0;
      dinLat  <= mem_din0;
   end

   always @(negedge clk0) begin
      if (csbLat === 1'b0) begin
         if (webLat === 1'b0) memArray[addrLat] = dinLat;
         else                 mem_dout0 = memArray[addrLat];
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   // One clock cycle: wait for posedge, drive reset and both requesters, let combinational outputs settle.
   task automatic applyStimulus(input logic rst, input logic av, input logic awe, input logic [AW-1:0] aad,
                                input logic [DW-1:0] awd, input logic bv, input logic bwe,
                                input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
      @(posedge clk0);
      #1;
      rstb0 = rst;
      a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
      b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   logic expA [6];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstb0 = 1'b0;
      a_valid = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;

      // Reset held with both requesters asserting valid.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
         checkOutput("rst_a_ready", 16'(a_ready), 16'h0);
         checkOutput("rst_b_ready", 16'(b_ready), 16'h0);
         checkOutput("rst_csb", 16'(mem_csb0), 16'h1);
         checkOutput("rst_rvalid", 16'({a_rvalid, b_rvalid}), 16'h0);
         if (c == 2) begin
            checkOutput("rst_web", 16'(mem_web0), 16'h1);
            checkOutput("rst_addr", 16'(mem_addr0), 16'h0);
            checkOutput("rst_din", 16'(mem_din0), 16'h0);
            checkOutput("rst_rdata", 16'({a_rdata, b_rdata}), 16'h0);
         end
      end
      applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
      checkOutput("post_rst_a_ready", 16'(a_ready), 16'h1);
      checkOutput("post_rst_b_ready", 16'(b_ready), 16'h0);
      for (int c = 0; c < 4; c++) idle();

      // A writes 1A5 then reads it back on the next cycle.
      applyStimulus(1'b1, 1'b1, 1'b1, 9'h1A5, 8'h3C, 1'b0, 1'b0, '0, '0);
      checkOutput("wr_a_ready", 16'(a_ready), 16'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 9'h1A5, 8'h00, 1'b0, 1'b0, '0, '0);
      checkOutput("rd_a_ready", 16'(a_ready), 16'h1);
      checkOutput("wr_csb", 16'(mem_csb0), 16'h0);
      checkOutput("wr_web", 16'(mem_web0), 16'h0);
      checkOutput("wr_addr", 16'(mem_addr0), 16'h1A5);
      checkOutput("wr_din", 16'(mem_din0), 16'h3C);
      idle();
      checkOutput("rd_csb", 16'(mem_csb0), 16'h0);
      checkOutput("rd_web", 16'(mem_web0), 16'h1);
      idle();
      checkOutput("idle_csb", 16'(mem_csb0), 16'h1);
      checkOutput("idle_addr_hold", 16'(mem_addr0), 16'h1A5);
      checkOutput("rd_early_rvalid", 16'(a_rvalid), 16'h0);
      idle();
      checkOutput("rd_a_rvalid", 16'(a_rvalid), 16'h1);
      checkOutput("rd_a_rdata", 16'(a_rdata), 16'h3C);
      checkOutput("rd_b_rvalid", 16'(b_rvalid), 16'h0);
      idle();
      checkOutput("rd_a_rvalid_pulse", 16'(a_rvalid), 16'h0);
      checkOutput("rd_a_rdata_hold", 16'(a_rdata), 16'h3C);

      // Contention after a fresh reset: A reads 040 (E5), B reads 081 (24).
      for (int k = 0; k < 6; k++) begin
`ifdef SRAM_ARB_RR_EN
         expA[k] = (k % 2 == 0);
`else
         expA[k] = 1'b1;
`endif
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      for (int c = 0; c < 10; c++) begin
         if (c < 6) applyStimulus(1'b1, 1'b1, 1'b0, 9'h040, '0, 1'b1, 1'b0, 9'h081, '0);
         else       idle();
         if (c < 6) begin
            checkOutput($sformatf("cont_a_ready_%0d", c), 16'(a_ready), 16'(expA[c]));
            checkOutput($sformatf("cont_b_ready_%0d", c), 16'(b_ready), 16'(!expA[c]));
         end
         if (c >= 3 && c < 9) begin
            checkOutput($sformatf("cont_a_rvalid_%0d", c), 16'(a_rvalid), 16'(expA[c-3]));
            checkOutput($sformatf("cont_b_rvalid_%0d", c), 16'(b_rvalid), 16'(!expA[c-3]));
            if (expA[c-3]) checkOutput($sformatf("cont_a_rdata_%0d", c), 16'(a_rdata), 16'hE5);
            else           checkOutput($sformatf("cont_b_rdata_%0d", c), 16'(b_rdata), 16'h24);
         end
         if (c == 9) checkOutput("cont_drain", 16'({a_rvalid, b_rvalid}), 16'h0);
      end

      // Reset pulsed while an A read of 000 is in flight.
      applyStimulus(1'b1, 1'b1, 1'b1, 9'h000, 8'h5A, 1'b0, 1'b0, '0, '0);
      for (int c = 0; c < 3; c++) idle();
      applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("mid_rd_ready", 16'(a_ready), 16'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 9'h000, '0, 1'b1, 1'b0, 9'h000, '0);
      checkOutput("mid_rst_ready", 16'({a_ready, b_ready}), 16'h0);
      for (int c = 0; c < 4; c++) begin
         idle();
         checkOutput($sformatf("mid_no_rvalid_%0d", c), 16'(a_rvalid), 16'h0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 9'h000, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("mid_fresh_ready", 16'(a_ready), 16'h1);
      idle();
      idle();
      idle();
      checkOutput("mid_fresh_rvalid", 16'(a_rvalid), 16'h1);
      checkOutput("mid_fresh_rdata", 16'(a_rdata), 16'h5A);

      // B writes 010..017, then A streams reads back-to-back.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 9'(9'h010 + i), 8'(8'h10 + i));
         checkOutput($sformatf("strm_b_ready_%0d", i), 16'({a_ready, b_ready}), 16'h1);
      end
      for (int c = 0; c < 12; c++) begin
         if (c < 8) applyStimulus(1'b1, 1'b1, 1'b0, 9'(9'h010 + c), '0, 1'b0, 1'b0, '0, '0);
         else       idle();
         if (c < 8) checkOutput($sformatf("strm_a_ready_%0d", c), 16'(a_ready), 16'h1);
         if (c >= 3 && c < 11) begin
            checkOutput($sformatf("strm_a_rvalid_%0d", c), 16'(a_rvalid), 16'h1);
            checkOutput($sformatf("strm_a_rdata_%0d", c), 16'(a_rdata), 16'(8'h10 + c - 3));
            checkOutput($sformatf("strm_b_rvalid_%0d", c), 16'(b_rvalid), 16'h0);
         end
         if (c == 11) checkOutput("strm_drain", 16'(a_rvalid), 16'h0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for port 0 of the 512x8 dual-port SRAM macro in the systolic array. Requester A (host loader) and requester B (array fetch/writeback) each issue single-word read/write requests over a valid/ready handshake. The arbiter drives the macro's registered port 0 and returns read data, tagged to the issuing requester, at a fixed latency. Port 1 of the macro is not touched by this block.

## Interface
- DATA_WIDTH, 8, word width; matches macro.
- ADDR_WIDTH, 9, address width; matches macro (512 words).

- clk0  in  1  clock; also drives macro clk0.
- rstb0  in  1  synchronous active-low reset.
- a_valid  in  1  requester A request valid.
- a_ready  out  1  A request accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  A word address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_rvalid  out  1  A read data valid, one-cycle pulse.
- a_rdata  out  DATA_WIDTH  A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for requester B.
- mem_csb0  out  1  macro chip select, active low.
- mem_web0  out  1  macro write enable, active low.
- mem_addr0  out  ADDR_WIDTH  macro address.
- mem_din0  out  DATA_WIDTH  macro write data.
- mem_dout0  in  DATA_WIDTH  macro read data.

## Operation
- Accepts at most one request per cycle. Handshake completes on a posedge with x_valid && x_ready.
- x_ready is combinational: high only for the granted requester, and only if that requester's valid is high. Both readies are never high together.
- Arbitration (SRAM_ARB_RR_EN defined): round robin.
  - A last_grant flag records the most recent handshake.
  - If both requesters are valid, grant goes to the one not recorded in last_grant.
  - A single valid requester always wins.
  - last_grant updates only on a handshake.
- A granted request is registered onto the macro outputs at the handshake posedge:
  - mem_csb0 = 0.
  - mem_web0 = ~we.
  - mem_addr0 = addr.
  - mem_din0 = wdata.
- In a cycle with no handshake, the next posedge sets mem_csb0 = 1 and mem_web0 = 1. mem_addr0 and mem_din0 hold their previous values.
- Each read pushes a tag (A/B) into a 2-stage shift pipeline that tracks in-flight reads. Writes push an empty slot.
- When the tag reaches the capture stage, mem_dout0 is registered into that requester's rdata and its rvalid pulses for one cycle.
- rdata of the other requester holds its previous value.
- Responses have no backpressure: requesters must accept rvalid unconditionally.
- Same-address hazards resolve in issue order. A read issued in the cycle after a write to the same address returns the new data, because the macro writes at the negedge before it reads.
- Reset (rstb0 = 0 at a posedge), including in the middle of a transfer:
  - a_ready = b_ready = 0 for the whole reset.
  - mem_csb0 = 1, mem_web0 = 1, mem_addr0 = 0, mem_din0 = 0.
  - rvalid outputs = 0, rdata outputs = 0.
  - Tag pipeline cleared: in-flight reads produce no rvalid.
  - last_grant = B, so A wins first.

## Timing
- Cycle T: handshake at the posedge ending T.
- Cycle T+1: macro port 0 inputs stable. The macro samples them at the posedge ending T+1.
- Cycle T+2: the macro drives dout0 after the negedge. The value is stable before the posedge ending T+2, where the arbiter captures it.
- Cycle T+3: x_rvalid = 1 and x_rdata is valid. Read latency is 3 cycles from the handshake cycle.
- Writes commit in the macro at the negedge inside T+2.
- Back-to-back reads give one rvalid per cycle with the same 3-cycle latency.
- Throughput is one request per cycle, sustained.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration as described above.
- SRAM_ARB_RR_EN undefined: fixed priority, A always wins when a_valid = 1 (B may starve). The last_grant flag is not built.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset then idle: hold rstb0 = 0 for 3 cycles with a_valid = b_valid = 1.
  - During reset: both ready = 0, mem_csb0 = 1, no rvalid.
  - First cycle after release: a_ready = 1.
- Write then read by A: write addr 9'h1A5 data 8'h3C, next cycle read 9'h1A5.
  - a_rvalid pulses 3 cycles after the read handshake with a_rdata = 8'h3C.
  - b_rvalid stays 0.
- Contention (RR build): a_valid and b_valid both held high for 6 cycles, all reads.
  - Grants alternate A,B,A,B,A,B.
  - rvalid pulses alternate with matching data and 3-cycle latency.
- Contention (fixed build): same stimulus.
  - a_ready = 1 for all 6 cycles, b_ready = 0 throughout.
- Reset mid-flight: A reads 9'h000; rstb0 is pulsed low in cycle T+1.
  - No a_rvalid follows.
  - After reset, a fresh read of 9'h000 returns the value previously written there.
- Interleaved stream: B writes 9'h010..9'h017 with data = addr[7:0], then A reads 9'h010..9'h017 back-to-back.
  - 8 consecutive a_rvalid pulses with data 8'h10..8'h17 in order.
